// File: rtl/fft_pkg.sv
// Shared FFT-chain definitions: frame error codes, default sample/exponent
// widths and the per-sample framing flags carried alongside the data path.
package fft_pkg;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned EXP_W_DEF = 6;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NO_SOP  = 2'b01;
  localparam logic [1:0] ERR_NO_EOP  = 2'b10;
  localparam logic [1:0] ERR_BAD_EOP = 2'b11;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [1:0] err;
  } frame_flags_t;

endpackage

// File: rtl/fft_bfp_shift_sat.sv
// Combinational block-floating-point rescale of one signed component:
// left shift with saturation, or arithmetic (floor) right shift.
module fft_bfp_shift_sat #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned SH_W  = $clog2(OUT_W + 1)
) (
  input  logic [IN_W-1:0]  x,
  input  logic             shl,
  input  logic [SH_W-1:0]  amt,
  output logic [OUT_W-1:0] y_c,
  output logic             sat_c
);

  localparam int unsigned WW = IN_W + OUT_W;

  logic signed [WW-1:0]    x_ext;
  logic signed [WW-1:0]    shl_v;
  logic        [OUT_W-1:0] shr_v;
  logic        [IN_W:0]    top_bits;

  // Amount never exceeds OUT_W, so the WW-wide left shift cannot lose bits.
  always_comb begin
    x_ext    = {{OUT_W{x[IN_W-1]}}, x};
    shl_v    = x_ext <<< amt;
    shr_v    = OUT_W'(x_ext >>> amt);
    top_bits = shl_v[WW-1:OUT_W-1];
    sat_c    = shl & ~((&top_bits) | ~(|top_bits));
    y_c      = shl ? shl_v[OUT_W-1:0] : shr_v;
    if (sat_c) begin
      y_c = shl_v[WW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fft_bfp_denorm.sv
// Post-FFT stage: rescales block-floating-point samples to a common fixed-point
// format with saturation, and checks sop/eop framing against FFT_LEN.
module fft_bfp_denorm
  import fft_pkg::*;
#(
  parameter int unsigned IN_W    = IN_W_DEF,
  parameter int unsigned OUT_W   = 24,
  parameter int unsigned EXP_W   = EXP_W_DEF,
  parameter int unsigned FFT_LEN = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [1:0]       sink_error,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [IN_W-1:0]  sink_real,
  input  logic [IN_W-1:0]  sink_imag,
  input  logic [EXP_W-1:0] sink_exp,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [OUT_W-1:0] source_real,
  output logic [OUT_W-1:0] source_imag,
  output logic             source_sat
);

  localparam int unsigned CNT_W = $clog2(FFT_LEN + 1);
  localparam int unsigned SH_W  = $clog2(OUT_W + 1);
  localparam int unsigned XW    = EXP_W + 1;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [EXP_W-1:0] exp_q, exp_d;

  logic             en_c;
  logic             accept_c;
  logic             fwd_c;
  frame_flags_t     flags_c;

  logic [EXP_W-1:0] exp_eff_c;
  logic [XW-1:0]    exp_ext_c;
  logic [XW-1:0]    mag_c;
  logic             shl_c;
  logic [SH_W-1:0]  amt_c;

  logic             s1_valid;
  frame_flags_t     s1_flags;
  logic [IN_W-1:0]  s1_real, s1_imag;
  logic             s1_shl;
  logic [SH_W-1:0]  s1_amt;

  logic             s2_valid;
  logic [OUT_W-1:0] re_c, im_c;
  logic             re_sat_c, im_sat_c;

  // Both stages advance together whenever the output register can move.
  assign en_c         = ~s2_valid | source_ready;
  assign sink_ready   = ~reset & en_c;
  assign accept_c     = sink_valid & sink_ready;
  assign source_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  // Framing decision for the accepted beat; a sop always opens a new frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    fwd_c   = 1'b0;
    flags_c = '0;
    cnt_inc = cnt_q + CNT_W'(1);
    if (accept_c) begin
      if (sink_sop) begin
        fwd_c       = 1'b1;
        exp_d       = sink_exp;
        cnt_d       = CNT_W'(1);
        flags_c.sop = 1'b1;
        flags_c.eop = sink_eop;
        flags_c.err = ERR_OK;
        state_d     = ST_IN_FRAME;
        if (FFT_LEN == 1) begin
          flags_c.eop = 1'b1;
          state_d     = ST_IDLE;
          if (!sink_eop) flags_c.err = ERR_NO_EOP;
        end else if (sink_eop) begin
          flags_c.err = ERR_BAD_EOP;
          state_d     = ST_IDLE;
        end
        if (state_q == ST_IN_FRAME) flags_c.err = ERR_NO_EOP;
      end else if (state_q == ST_IN_FRAME) begin
        fwd_c       = 1'b1;
        cnt_d       = cnt_inc;
        flags_c.eop = sink_eop;
        flags_c.err = ERR_OK;
        if (cnt_inc == CNT_W'(FFT_LEN)) begin
          flags_c.eop = 1'b1;
          state_d     = ST_IDLE;
          if (!sink_eop) flags_c.err = ERR_NO_EOP;
        end else if (sink_eop) begin
          flags_c.err = ERR_BAD_EOP;
          state_d     = ST_IDLE;
        end
      end
      if (sink_error != ERR_OK) flags_c.err = sink_error;
    end
  end

  // The sop beat scales with its own exponent; later beats use the latched one.
  always_comb begin
    exp_eff_c = sink_sop ? sink_exp : exp_q;
    exp_ext_c = {exp_eff_c[EXP_W-1], exp_eff_c};
    mag_c     = exp_ext_c[EXP_W] ? (~exp_ext_c + XW'(1)) : exp_ext_c;
    shl_c     = exp_ext_c[EXP_W] | (exp_eff_c == '0);
    amt_c     = (32'(mag_c) > OUT_W) ? SH_W'(OUT_W) : SH_W'(mag_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_flags <= '0;
      s1_real  <= '0;
      s1_imag  <= '0;
      s1_shl   <= 1'b0;
      s1_amt   <= '0;
    end else if (en_c) begin
      s1_valid <= accept_c & fwd_c;
      if (accept_c & fwd_c) begin
        s1_flags <= flags_c;
        s1_real  <= sink_real;
        s1_imag  <= sink_imag;
        s1_shl   <= shl_c;
        s1_amt   <= amt_c;
      end
    end
  end

  fft_bfp_shift_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_shift_re (
    .x     (s1_real),
    .shl   (s1_shl),
    .amt   (s1_amt),
    .y_c   (re_c),
    .sat_c (re_sat_c)
  );

  fft_bfp_shift_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_shift_im (
    .x     (s1_imag),
    .shl   (s1_shl),
    .amt   (s1_amt),
    .y_c   (im_c),
    .sat_c (im_sat_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid     <= 1'b0;
      source_error <= ERR_OK;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
      source_sat   <= 1'b0;
    end else if (en_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        source_error <= s1_flags.err;
        source_sop   <= s1_flags.sop;
        source_eop   <= s1_flags.eop;
        source_real  <= re_c;
        source_imag  <= im_c;
        source_sat   <= re_sat_c | im_sat_c;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfp_denorm.sv
// Directed bench for fft_bfp_denorm (FFT_LEN=4): vector table, backpressure
// sequence and mid-frame reset, checked against a scoreboard of expected outputs.
`timescale 1ns/1ps
module tb_fft_bfp_denorm;
  import fft_pkg::*;

  localparam int unsigned IN_W    = 16;
  localparam int unsigned OUT_W   = 24;
  localparam int unsigned EXP_W   = 6;
  localparam int unsigned FFT_LEN = 4;

  typedef struct {
    logic             sop;
    logic             eop;
    logic [1:0]       err;
    logic [IN_W-1:0]  re;
    logic [IN_W-1:0]  im;
    logic [EXP_W-1:0] ex;
    logic             fwd;
    logic             e_sop;
    logic             e_eop;
    logic [1:0]       e_err;
    logic [OUT_W-1:0] e_re;
    logic [OUT_W-1:0] e_im;
    logic             e_sat;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             sink_valid;
  logic             sink_ready;
  logic [1:0]       sink_error;
  logic             sink_sop;
  logic             sink_eop;
  logic [IN_W-1:0]  sink_real;
  logic [IN_W-1:0]  sink_imag;
  logic [EXP_W-1:0] sink_exp;
  logic             source_valid;
  logic             source_ready;
  logic [1:0]       source_error;
  logic             source_sop;
  logic             source_eop;
  logic [OUT_W-1:0] source_real;
  logic [OUT_W-1:0] source_imag;
  logic             source_sat;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t tbl[27];
  vec_t stl[8];
  logic seen_bp = 1'b0;

  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] prev_re, prev_im;
  logic [1:0]       prev_err;
  logic             prev_sop, prev_eop, prev_sat;

  always #5 clk = ~clk;

  fft_bfp_denorm #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .EXP_W   (EXP_W),
    .FFT_LEN (FFT_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_error   (sink_error),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_exp     (sink_exp),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_error (source_error),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_sat   (source_sat)
  );

  function automatic vec_t mk(logic sop, logic eop, logic [1:0] err, int re, int im, int ex,
                              logic fwd, logic e_sop, logic e_eop, logic [1:0] e_err,
                              int e_re, int e_im, logic e_sat);
    vec_t v;
    v.sop = sop;  v.eop = eop;  v.err = err;
    v.re  = IN_W'(re);  v.im = IN_W'(im);  v.ex = EXP_W'(ex);
    v.fwd = fwd;  v.e_sop = e_sop;  v.e_eop = e_eop;  v.e_err = e_err;
    v.e_re = OUT_W'(e_re);  v.e_im = OUT_W'(e_im);  v.e_sat = e_sat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    sink_sop   = v.sop;
    sink_eop   = v.eop;
    sink_error = v.err;
    sink_real  = v.re;
    sink_imag  = v.im;
    sink_exp   = v.ex;
  endtask

  // Holds the beat until it is accepted; called #1 after a rising edge.
  task automatic drive_vec(input vec_t v);
    logic acc;
    int   n;
    set_inputs(v);
    sink_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = sink_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: sink_ready stayed 0 for %0d cycles, expected 1", n);
    end else if (v.fwd) begin
      exp_q.push_back(v);
    end
    sink_valid = 1'b0;
  endtask

  // Output monitor: scoreboard compare on transfers, hold check while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (!sink_ready) seen_bp = 1'b1;
      if (stall_prev) begin
        checks++;
        if (source_valid !== 1'b1 || source_real !== prev_re || source_imag !== prev_im ||
            source_error !== prev_err || source_sop !== prev_sop ||
            source_eop !== prev_eop || source_sat !== prev_sat) begin
          errors++;
          $display("FAIL hold: outputs changed while stalled (v=%0b re=%0d), expected v=1 re=%0d",
                   source_valid, $signed(source_real), $signed(prev_re));
        end
      end
      stall_prev = source_valid & ~source_ready;
      prev_re  = source_real;  prev_im  = source_imag;  prev_err = source_error;
      prev_sop = source_sop;   prev_eop = source_eop;   prev_sat = source_sat;
      if (source_valid && source_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_output: got re=%0d im=%0d, expected no output",
                   $signed(source_real), $signed(source_imag));
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          if (source_real !== e.e_re || source_imag !== e.e_im || source_sat !== e.e_sat ||
              source_sop !== e.e_sop || source_eop !== e.e_eop || source_error !== e.e_err) begin
            errors++;
            $display("FAIL out: got re=%0d im=%0d sat=%0b sop=%0b eop=%0b err=%0d, expected re=%0d im=%0d sat=%0b sop=%0b eop=%0b err=%0d",
                     $signed(source_real), $signed(source_imag), source_sat, source_sop,
                     source_eop, source_error, $signed(e.e_re), $signed(e.e_im), e.e_sat,
                     e.e_sop, e.e_eop, e.e_err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // sop eop err  re      im      exp  fwd esop eeop eerr  e_re     e_im     esat
    tbl[0]  = mk(1, 0, 0, 100,    -5,     -3,  1, 1, 0, 0, 800,     -40,      0);
    tbl[1]  = mk(0, 0, 0, 100,    -5,      5,  1, 0, 0, 0, 800,     -40,      0);
    tbl[2]  = mk(0, 0, 0, 100,    -5,      5,  1, 0, 0, 0, 800,     -40,      0);
    tbl[3]  = mk(0, 1, 0, 100,    -5,      0,  1, 0, 1, 0, 800,     -40,      0);
    tbl[4]  = mk(1, 0, 0, -7,     7,       2,  1, 1, 0, 0, -2,      1,        0);
    tbl[5]  = mk(0, 0, 0, 7,      -7,    -10,  1, 0, 0, 0, 1,       -2,       0);
    tbl[6]  = mk(0, 0, 0, -1,     1,       0,  1, 0, 0, 0, -1,      0,        0);
    tbl[7]  = mk(0, 1, 0, 8,      -8,      0,  1, 0, 1, 0, 2,       -2,       0);
    tbl[8]  = mk(1, 0, 0, 32767,  -32768, -20, 1, 1, 0, 0, 8388607, -8388608, 1);
    tbl[9]  = mk(0, 0, 0, 0,      0,       0,  1, 0, 0, 0, 0,       0,        0);
    tbl[10] = mk(0, 0, 0, 0,      1,       0,  1, 0, 0, 0, 0,       1048576,  0);
    tbl[11] = mk(0, 1, 0, -1,     0,       0,  1, 0, 1, 0, -1048576, 0,       0);
    tbl[12] = mk(1, 0, 0, 1,      1,       0,  1, 1, 0, 0, 1,       1,        0);
    tbl[13] = mk(0, 0, 0, 2,      2,       0,  1, 0, 0, 0, 2,       2,        0);
    tbl[14] = mk(0, 1, 0, 3,      3,       0,  1, 0, 1, 3, 3,       3,        0);
    tbl[15] = mk(0, 0, 0, 4,      4,       0,  0, 0, 0, 0, 0,       0,        0);
    tbl[16] = mk(0, 1, 0, 5,      5,       0,  0, 0, 0, 0, 0,       0,        0);
    tbl[17] = mk(1, 0, 0, 6,      6,       0,  1, 1, 0, 0, 6,       6,        0);
    tbl[18] = mk(0, 0, 0, 7,      7,       0,  1, 0, 0, 0, 7,       7,        0);
    tbl[19] = mk(1, 0, 0, 8,      8,       1,  1, 1, 0, 2, 4,       4,        0);
    tbl[20] = mk(0, 0, 0, 9,      9,       0,  1, 0, 0, 0, 4,       4,        0);
    tbl[21] = mk(0, 0, 0, -9,     -9,      0,  1, 0, 0, 0, -5,      -5,       0);
    tbl[22] = mk(0, 0, 0, 10,     10,      0,  1, 0, 1, 2, 5,       5,        0);
    tbl[23] = mk(1, 0, 1, 4,      -4,      1,  1, 1, 0, 1, 2,       -2,       0);
    tbl[24] = mk(0, 0, 0, 4,      4,       0,  1, 0, 0, 0, 2,       2,        0);
    tbl[25] = mk(0, 0, 2, 4,      4,       0,  1, 0, 0, 2, 2,       2,        0);
    tbl[26] = mk(0, 1, 0, 4,      4,       0,  1, 0, 1, 0, 2,       2,        0);

    stl[0] = mk(1, 0, 0, 10,  -1, -1, 1, 1, 0, 0, 20, -2, 0);
    stl[1] = mk(0, 0, 0, 20,  -2,  0, 1, 0, 0, 0, 40, -4, 0);
    stl[2] = mk(0, 0, 0, 30,  -3,  0, 1, 0, 0, 0, 60, -6, 0);
    stl[3] = mk(0, 1, 0, 40,  -4,  0, 1, 0, 1, 0, 80, -8, 0);
    stl[4] = mk(1, 0, 0, 11,  0,   1, 1, 1, 0, 0, 5,  0,  0);
    stl[5] = mk(0, 0, 0, -11, 1,   0, 1, 0, 0, 0, -6, 0,  0);
    stl[6] = mk(0, 0, 0, 3,   2,   0, 1, 0, 0, 0, 1,  1,  0);
    stl[7] = mk(0, 1, 0, -3,  -2,  0, 1, 0, 1, 0, -2, -1, 0);

    reset        = 1'b1;
    sink_valid   = 1'b1;
    source_ready = 1'b1;
    set_inputs(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sink_ready", 32'(sink_ready), 32'd0);
    chk("reset_source_valid", 32'(source_valid), 32'd0);
    chk("reset_source_data", {source_real[15:0], source_imag[15:0]}, 32'd0);
    chk("reset_source_flags", {28'd0, source_sop, source_eop, source_error}, 32'd0);
    sink_valid = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;

    // Two-cycle latency on the first beat of an empty pipeline.
    set_inputs(tbl[0]);
    sink_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(tbl[0]);
    chk("latency_1", 32'(source_valid), 32'd0);
    set_inputs(tbl[1]);
    @(posedge clk);
    #1;
    exp_q.push_back(tbl[1]);
    chk("latency_2", 32'(source_valid), 32'd1);
    sink_valid = 1'b0;
    for (int i = 2; i < 27; i++) drive_vec(tbl[i]);
    repeat (6) @(posedge clk);
    #1;
    chk("drain_table", 32'(exp_q.size()), 32'd0);

    // Backpressure with gaps in sink_valid.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive_vec(stl[i]);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 source_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 source_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("stall_backpressure_seen", 32'(seen_bp), 32'd1);
    chk("drain_stall", 32'(exp_q.size()), 32'd0);

    // One-cycle reset in the middle of a frame.
    drive_vec(mk(1, 0, 0, 50, 50, 0, 1, 1, 0, 0, 50, 50, 0));
    drive_vec(mk(0, 0, 0, 51, 51, 0, 1, 0, 0, 0, 51, 51, 0));
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_sink_ready", 32'(sink_ready), 32'd0);
    chk("midreset_source_valid", 32'(source_valid), 32'd0);
    chk("midreset_source_data", {source_real[15:0], source_imag[15:0]}, 32'd0);
    chk("midreset_source_flags", {27'd0, source_sat, source_sop, source_eop, source_error}, 32'd0);
    reset = 1'b0;
    drive_vec(mk(0, 0, 0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_vec(mk(1, 0, 0, 3,  -3, -1, 1, 1, 0, 0, 6,  -6, 0));
    drive_vec(mk(0, 0, 0, 4,  -4,  0, 1, 0, 0, 0, 8,  -8, 0));
    drive_vec(mk(0, 0, 0, 5,  -5,  0, 1, 0, 0, 0, 10, -10, 0));
    drive_vec(mk(0, 1, 0, -6, 6,   0, 1, 0, 1, 0, -12, 12, 0));
    repeat (6) @(posedge clk);
    #1;
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
